// File: rtl/send_packet.sv
// Serial packet transmitter: one header byte (0xA5/0xC3) followed by PAYLOAD_BYTES
// payload bytes pulled over valid/ready, sent LSB-first and qualified by data_ena.
module send_packet #(
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       header_sel,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       serial_data,
  output logic       data_ena,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (PAYLOAD_BYTES > 0) ? $clog2(PAYLOAD_BYTES + 1) : 1;
  localparam logic [7:0] HDR_A = 8'hA5;
  localparam logic [7:0] HDR_C = 8'hC3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [7:0]       shreg, shreg_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic             serial_d, ena_d, busy_d, done_d;

  // Upstream may hand over a byte only while waiting in LOAD
  assign byte_ready = (state == LOAD);

  // State register and registered outputs
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      serial_data <= 1'b0;
      data_ena    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      bit_cnt     <= bit_cnt_d;
      byte_cnt    <= byte_cnt_d;
      serial_data <= serial_d;
      data_ena    <= ena_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they line up with it
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_d    = header_sel ? HDR_C : HDR_A;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {1'b0, shreg[7:1]};
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt < CNT_W'(PAYLOAD_BYTES)) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (byte_valid) begin
          shreg_d    = byte_in;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = byte_cnt + CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase

    ena_d    = (state_d == SHIFT);
    serial_d = ena_d & shreg_d[0];
    busy_d   = (state_d != IDLE);
  end

endmodule

// File: tb/tb_send_packet.sv
// Directed bench for send_packet: per-cycle output masks against hand-derived
// windows, plus a small deserializer/header-detector model on the serial stream.
module tb_send_packet;

  logic       clk_50;
  logic       reset_n;
  logic       start_a, start_b;
  logic       header_sel;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       rdy_a, ser_a, ena_a, busy_a, done_a;
  logic       rdy_b, ser_b, ena_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_ena, m_ser, m_rdy, m_busy, m_done;
  logic [63:0] words;
  logic [7:0]  hflags;
  int          n_words;
  logic [7:0]  bytes [4];

  // Two-byte payload instance and header-only instance
  send_packet #(.PAYLOAD_BYTES(2)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_a), .header_sel(header_sel),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_a),
    .serial_data(ser_a), .data_ena(ena_a), .busy(busy_a), .done(done_a)
  );

  send_packet #(.PAYLOAD_BYTES(0)) dut0 (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_b), .header_sel(header_sel),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_b),
    .serial_data(ser_b), .data_ena(ena_b), .busy(busy_b), .done(done_b)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Launch one packet at cycle 0 and record outputs for cycles 1..63.
  // ign_c / restart_c pulse start (header_sel=1); rst_c asserts reset mid-cycle and returns.
  task automatic run(input bit use0, input bit hsel, input int stall,
                     input int ign_c, input int restart_c, input int rst_c);
    logic       s, e, r, b, d;
    logic [7:0] acc;
    int         nb, idx, stall_left;
    bit         consumed;
    m_ena = '0; m_ser = '0; m_rdy = '0; m_busy = '0; m_done = '0;
    words = '0; hflags = '0; n_words = 0;
    acc = '0; nb = 0; idx = 0; stall_left = stall;
    header_sel = hsel;
    byte_in    = bytes[0];
    byte_valid = 1'b1;
    if (use0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk_50); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 1; c < 64; c++) begin
      s = use0 ? ser_b  : ser_a;
      e = use0 ? ena_b  : ena_a;
      r = use0 ? rdy_b  : rdy_a;
      b = use0 ? busy_b : busy_a;
      d = use0 ? done_b : done_a;
      m_ser[c] = s; m_ena[c] = e; m_rdy[c] = r; m_busy[c] = b; m_done[c] = d;
      if (e) begin
        acc = {s, acc[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (n_words < 8) begin
            words[n_words*8 +: 8] = acc;
            hflags[n_words] = (acc == 8'hA5) || (acc == 8'hC3);
          end
          n_words++;
        end
      end
      if (c == ign_c || c == restart_c) begin
        start_a = 1'b1;
        header_sel = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      consumed = 1'b0;
      if (r && stall_left > 0) begin
        byte_valid = 1'b0;
        stall_left--;
      end else begin
        byte_valid = 1'b1;
        consumed = r;
      end
      if (c == rst_c) begin
        #4 reset_n = 1'b0;
        #1 check("reset_async_outputs", {59'd0, rdy_a, ser_a, ena_a, busy_a, done_a}, 64'd0);
        #4 reset_n = 1'b1;
        @(posedge clk_50); #1;
        return;
      end
      @(posedge clk_50); #1;
      if (consumed && idx < 3) idx++;
      byte_in = bytes[idx];
    end
    start_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; header_sel = 1'b0;
    byte_in = 8'd0; byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) bytes[i] = 8'd0;
    repeat (3) @(posedge clk_50);
    #1 check("reset_outputs", {54'd0, rdy_a, ser_a, ena_a, busy_a, done_a,
                               rdy_b, ser_b, ena_b, busy_b, done_b}, 64'd0);
    @(negedge clk_50) reset_n = 1'b1;
    @(posedge clk_50); #1;

    // Basic packet: A5, 3C, 81 with byte_valid held high
    bytes[0] = 8'h3C; bytes[1] = 8'h81; bytes[2] = 8'h00; bytes[3] = 8'h00;
    run(1'b0, 1'b0, 0, -1, -1, -1);
    check("basic_bits",  words, 64'h813CA5);
    check("basic_ena",   m_ena,  rng(1,8) | rng(10,17) | rng(19,26));
    check("basic_ready", m_rdy,  rng(9,9) | rng(18,18));
    check("basic_busy",  m_busy, rng(1,26));
    check("basic_done",  m_done, rng(27,27));
    check("basic_gap_zero", m_ser & ~m_ena, 64'd0);
    check("basic_hdr_flags", 64'(hflags), 64'h1);

    // Stall: five idle cycles in the first LOAD
    bytes[0] = 8'h5A; bytes[1] = 8'h0F;
    run(1'b0, 1'b1, 5, -1, -1, -1);
    check("stall_bits",  words, 64'h0F5AC3);
    check("stall_ena",   m_ena,  rng(1,8) | rng(15,22) | rng(24,31));
    check("stall_ready", m_rdy,  rng(9,14) | rng(23,23));
    check("stall_done",  m_done, rng(32,32));
    check("stall_gap_zero", m_ser & ~m_ena, 64'd0);

    // Start ignored mid-packet, then accepted in the done cycle
    bytes[0] = 8'h3C; bytes[1] = 8'h81; bytes[2] = 8'h5A; bytes[3] = 8'h0F;
    run(1'b0, 1'b0, 0, 12, 27, -1);
    check("ign_bits",  words, 64'h0F5AC3813CA5);
    check("ign_ena",   m_ena,  rng(1,8) | rng(10,17) | rng(19,26) |
                               rng(28,35) | rng(37,44) | rng(46,53));
    check("ign_busy",  m_busy, rng(1,26) | rng(28,53));
    check("ign_done",  m_done, rng(27,27) | rng(54,54));
    check("ign_hdr_flags", 64'(hflags), 64'h9);

    // Header-only instance
    run(1'b1, 1'b0, 0, -1, -1, -1);
    check("hdr_only_bits",  words, 64'hA5);
    check("hdr_only_ena",   m_ena,  rng(1,8));
    check("hdr_only_ready", m_rdy,  64'd0);
    check("hdr_only_done",  m_done, rng(9,9));
    check("hdr_only_busy",  m_busy, rng(1,8));

    // Reset during the first payload byte, then a clean packet
    bytes[0] = 8'h3C; bytes[1] = 8'h81; bytes[2] = 8'h00; bytes[3] = 8'h00;
    run(1'b0, 1'b0, 0, -1, -1, 12);
    check("post_reset_idle", {60'd0, ena_a, busy_a, done_a, rdy_a}, 64'd0);
    run(1'b0, 1'b0, 0, -1, -1, -1);
    check("post_reset_bits", words, 64'h813CA5);
    check("post_reset_done", m_done, rng(27,27));
    check("post_reset_ena",  m_ena,  rng(1,8) | rng(10,17) | rng(19,26));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/send_packet.md
# send_packet

Serial packet transmitter for the 50 MHz serial link. On `start` it emits a one-byte header (0xA5 or 0xC3), then `PAYLOAD_BYTES` payload bytes pulled from an upstream byte source through a valid/ready handshake. Bytes are sent LSB-first on `serial_data`, qualified by `data_ena`, in the exact format the downstream word deserializer and header detector consume. It sits between the packet-building logic and the serial link.

## Interface
- `PAYLOAD_BYTES`, default 4: payload bytes per packet after the header. Legal range is 0..255.
- `clk_50`  in  1  50 MHz clock. All state changes on the rising edge.
- `reset_n`  in  1  Reset, asynchronous, active-low.
- `start`  in  1  Request to send one packet. Sampled only in IDLE.
- `header_sel`  in  1  Header select, captured with `start`: 0 selects 0xA5, 1 selects 0xC3.
- `byte_in`  in  8  Payload byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  Transmitter will accept `byte_in` this cycle.
- `serial_data`  out  1  Serial bit, LSB-first. Driven 0 whenever `data_ena` = 0.
- `data_ena`  out  1  `serial_data` carries a valid bit this cycle.
- `busy`  out  1  A packet is in progress.
- `done`  out  1  One-cycle pulse after the last bit of a packet.

## Operation
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, byte counter 0.
- All outputs are registered, except `byte_ready`, which decodes state LOAD directly.
- State machine:
  - IDLE: if `start`=1, load the shift register with the selected header, clear the counters and go to SHIFT.
  - SHIFT: `data_ena`=1 and `serial_data` = shreg[0]. Each cycle, shift the register right and increment the 3-bit bit counter.
  - On bit 7 (counter = 7):
    - If header or payload bytes sent < `PAYLOAD_BYTES`, go to LOAD.
    - Otherwise go to IDLE and set `done`.
  - LOAD: `byte_ready`=1, `data_ena`=0. On `byte_valid`=1, capture `byte_in`, increment the byte counter and go to SHIFT. Otherwise stay in LOAD indefinitely.
- `PAYLOAD_BYTES`=0: header only, then `done`.
- `byte_in` is captured only on a handshake cycle. A `byte_valid` outside LOAD is ignored and not consumed.
- `header_sel` is captured only on an accepted `start`.
- `start` while `busy`=1 is ignored and not queued.
- `busy`=1 in SHIFT and LOAD, 0 in IDLE (including the `done` cycle).
- `done` is high exactly one cycle. A `start` in the `done` cycle is accepted, because the state is already IDLE.
- Byte counter width is $clog2(PAYLOAD_BYTES+1), minimum 1. Counters do not wrap within a packet.
- Reset mid-packet: return to IDLE immediately with all outputs 0. The partial packet is abandoned and not resumed.

## Timing
- Cycle numbers count from the edge that samples `start`.
- Header occupies cycles 1..8, bit k in cycle k+1, with `data_ena`=1.
- Payload:
  - Cycle 9 is LOAD.
  - With `byte_valid` held 1, each payload byte costs 9 cycles: 1 LOAD cycle plus 8 bit cycles.
  - So `data_ena` drops for exactly 1 cycle between bytes.
  - Each extra cycle of `byte_valid`=0 extends the gap by 1. During the gap, `serial_data`=0 and `data_ena`=0.
- `done` is asserted in cycle 9 + 9·`PAYLOAD_BYTES` when there are no stalls.
- The downstream deserializer counts only `data_ena` cycles, so gaps are transparent to it.

## Test plan
- **Basic packet.** Reset, then `start` with `header_sel`=0, `PAYLOAD_BYTES`=2, bytes 0x3C then 0x81, `byte_valid` held 1.
  - `serial_data` over `data_ena` cycles: 1,0,1,0,0,1,0,1 | 0,0,1,1,1,1,0,0 | 1,0,0,0,0,0,0,1.
  - `data_ena` low in cycles 9 and 18.
  - `done` only in cycle 27. `busy` high in cycles 1..26.
- **Stall.** `header_sel`=1 (0xC3), `byte_valid` low for 5 cycles in the first LOAD.
  - `byte_ready` high for 6 cycles.
  - `data_ena` low for 6 cycles.
  - Byte bits start the cycle after the handshake. `done` is delayed by 5 cycles.
- **Ignored start.** Pulse `start` with `header_sel`=1 during a packet's payload.
  - No effect; the current packet completes.
  - A `start` in the `done` cycle launches the next packet, with header bits beginning the next cycle.
- **Header only.** `PAYLOAD_BYTES`=0 with 0xA5.
  - 8 `data_ena` cycles, `byte_ready` never asserted, `done` in cycle 9.
- **Reset mid-packet.** Assert `reset_n`=0 asynchronously mid-byte.
  - All outputs 0 immediately.
  - After release, a new `start` produces a complete, correct packet.
- **Loopback.** Drive the downstream deserializer from this block.
  - Its word output equals 0xA5, 0x3C, 0x81 in order.
  - Header detection flags only the header word.
